// File: rtl/nx_fifo_ctrl_thresh.sv
// FIFO pointer/occupancy controller for an external RAM of any depth, with threshold flags.
// Optional peak-occupancy tracking is enabled by defining NX_FIFO_CTRL_WATERMARK_EN.
module nx_fifo_ctrl_thresh #(
  parameter int unsigned DEPTH = 6,
  parameter int unsigned PTR_W = $clog2(DEPTH),
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wen,
  input  logic             ren,
  input  logic             clear,
  input  logic [CNT_W-1:0] afull_thresh,
  input  logic [CNT_W-1:0] aempty_thresh,
  input  logic             err_clr,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CNT_W-1:0] used_slots,
  output logic [CNT_W-1:0] free_slots,
  output logic [PTR_W-1:0] rptr,
  output logic [PTR_W-1:0] wptr,
  output logic             underflow,
  output logic             overflow,
  output logic [1:0]       err_sticky,
  output logic [CNT_W-1:0] watermark
);

  localparam logic [PTR_W-1:0] PtrLast  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CntDepth = CNT_W'(DEPTH);

  logic             wr_acc, rd_acc;
  logic [PTR_W-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CNT_W-1:0] used_q, used_d, free_q, free_d;
  logic             empty_q, empty_d, full_q, full_d;
  logic             afull_q, afull_d, aempty_q, aempty_d;
  logic [1:0]       err_q, err_d;

  assign underflow = ren & empty_q;
  assign overflow  = wen & full_q;

  always_comb begin
    wr_acc = wen & ~full_q & ~clear;
    rd_acc = ren & ~empty_q & ~clear;
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    used_d = used_q;
    if (clear) begin
      rptr_d = '0;
      wptr_d = '0;
      used_d = '0;
    end else begin
      // Explicit wrap so non-power-of-2 depths address only valid RAM rows
      if (wr_acc) wptr_d = (wptr_q == PtrLast) ? '0 : wptr_q + PTR_W'(1);
      if (rd_acc) rptr_d = (rptr_q == PtrLast) ? '0 : rptr_q + PTR_W'(1);
      if (wr_acc && !rd_acc) begin
        used_d = used_q + CNT_W'(1);
      end else if (rd_acc && !wr_acc) begin
        used_d = used_q - CNT_W'(1);
      end
    end
    free_d   = CntDepth - used_d;
    empty_d  = (used_d == '0);
    full_d   = (used_d == CntDepth);
    afull_d  = (used_d >= afull_thresh);
    aempty_d = (used_d <= aempty_thresh);
    err_d[0] = underflow | (err_q[0] & ~err_clr);
    err_d[1] = overflow  | (err_q[1] & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rptr_q   <= '0;
      wptr_q   <= '0;
      used_q   <= '0;
      free_q   <= CntDepth;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= (afull_thresh == '0);
      aempty_q <= 1'b1;
      err_q    <= '0;
    end else begin
      rptr_q   <= rptr_d;
      wptr_q   <= wptr_d;
      used_q   <= used_d;
      free_q   <= free_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      err_q    <= err_d;
    end
  end

  assign rptr         = rptr_q;
  assign wptr         = wptr_q;
  assign used_slots   = used_q;
  assign free_slots   = free_q;
  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign err_sticky   = err_q;

`ifdef NX_FIFO_CTRL_WATERMARK_EN
  logic [CNT_W-1:0] wm_q, wm_d;

  always_comb begin
    wm_d = wm_q;
    if (clear) begin
      wm_d = '0;
    end else if (err_clr) begin
      wm_d = used_d;
    end else if (used_d > wm_q) begin
      wm_d = used_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wm_q <= '0;
    end else begin
      wm_q <= wm_d;
    end
  end

  assign watermark = wm_q;
`else
  assign watermark = '0;
`endif

endmodule

// File: tb/tb_nx_fifo_ctrl_thresh.sv
// Randomised and directed bench for nx_fifo_ctrl_thresh against an occupancy/counter model.
module tb_nx_fifo_ctrl_thresh;

  localparam int unsigned D  = 6;
  localparam int unsigned CW = $clog2(D + 1);
  localparam int unsigned PW = $clog2(D);

  logic          clk, rst_n, wen, ren, clear, err_clr;
  logic [CW-1:0] afth, aeth;
  logic          empty, full, almost_full, almost_empty, underflow, overflow;
  logic [CW-1:0] used_slots, free_slots, watermark;
  logic [PW-1:0] rptr, wptr;
  logic [1:0]    err_sticky;

  // Second instance with a depth of 5 for the odd-depth wrap check
  logic       rst5_n, wen5, ren5, clr5, eclr5;
  logic [2:0] afth5, aeth5, used5, free5, wm5;
  logic [2:0] rptr5, wptr5;
  logic       empty5, full5, af5, ae5, uf5, of5;
  logic [1:0] err5;

  int n_cmp, n_fail;
  int m_used, m_wc, m_rc, m_wm;
  logic [1:0] m_err;
  logic exp_of, exp_uf, obs_of, obs_uf;

  nx_fifo_ctrl_thresh #(.DEPTH(D)) u_dut (
    .clk(clk), .rst_n(rst_n), .wen(wen), .ren(ren), .clear(clear),
    .afull_thresh(afth), .aempty_thresh(aeth), .err_clr(err_clr),
    .empty(empty), .full(full), .almost_full(almost_full), .almost_empty(almost_empty),
    .used_slots(used_slots), .free_slots(free_slots), .rptr(rptr), .wptr(wptr),
    .underflow(underflow), .overflow(overflow), .err_sticky(err_sticky),
    .watermark(watermark)
  );

  nx_fifo_ctrl_thresh #(.DEPTH(5)) u_dut5 (
    .clk(clk), .rst_n(rst5_n), .wen(wen5), .ren(ren5), .clear(clr5),
    .afull_thresh(afth5), .aempty_thresh(aeth5), .err_clr(eclr5),
    .empty(empty5), .full(full5), .almost_full(af5), .almost_empty(ae5),
    .used_slots(used5), .free_slots(free5), .rptr(rptr5), .wptr(wptr5),
    .underflow(uf5), .overflow(of5), .err_sticky(err5), .watermark(wm5)
  );

  always #5 clk = ~clk;

  // Drive one cycle, sample combinational errors before the edge, then advance the model
  task automatic step(input logic w, input logic r, input logic c, input logic ec,
                      input logic rn);
    int wa, ra;
    wen = w; ren = r; clear = c; err_clr = ec; rst_n = rn;
    #1;
    obs_of = overflow;
    obs_uf = underflow;
    exp_of = w && (m_used == D);
    exp_uf = r && (m_used == 0);
    @(posedge clk);
    #1;
    if (!rn) begin
      m_used = 0; m_wc = 0; m_rc = 0; m_err = 2'b00; m_wm = 0;
    end else begin
      m_err = {exp_of | (m_err[1] & ~ec), exp_uf | (m_err[0] & ~ec)};
      if (c) begin
        m_used = 0; m_wc = 0; m_rc = 0;
      end else begin
        wa = (w && m_used < D) ? 1 : 0;
        ra = (r && m_used > 0) ? 1 : 0;
        m_wc += wa;
        m_rc += ra;
        m_used = m_used + wa - ra;
      end
`ifdef NX_FIFO_CTRL_WATERMARK_EN
      if (c) m_wm = 0;
      else if (ec) m_wm = m_used;
      else if (m_used > m_wm) m_wm = m_used;
`endif
    end
  endtask

  task automatic test_reset();
    afth = 4; aeth = 1;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty got %b want 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL rst_full got %b want 0", full); end
    n_cmp++; if (used_slots !== 0) begin n_fail++; $display("FAIL rst_used got %0d want 0", used_slots); end
    n_cmp++; if (free_slots !== 6) begin n_fail++; $display("FAIL rst_free got %0d want 6", free_slots); end
    n_cmp++; if (rptr !== 0 || wptr !== 0) begin n_fail++; $display("FAIL rst_ptr got %0d/%0d want 0/0", rptr, wptr); end
    n_cmp++; if (err_sticky !== 2'b00) begin n_fail++; $display("FAIL rst_err got %b want 00", err_sticky); end
    n_cmp++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin
      n_fail++; $display("FAIL rst_aflags got ae=%b af=%b want 1 0", almost_empty, almost_full);
    end
    n_cmp++; if (watermark !== 0) begin n_fail++; $display("FAIL rst_wm got %0d want 0", watermark); end
  endtask

  task automatic test_fill_wrap();
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, 0, 1);
      n_cmp++; if (wptr !== PW'((i + 1) % 6)) begin
        n_fail++; $display("FAIL fill_wptr got %0d want %0d", wptr, (i + 1) % 6);
      end
    end
    n_cmp++; if (full !== 1'b1 || used_slots !== 6) begin
      n_fail++; $display("FAIL fill_full got full=%b used=%0d want 1 6", full, used_slots);
    end
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0, 0, 1);
      n_cmp++; if (rptr !== PW'((i + 1) % 6)) begin
        n_fail++; $display("FAIL drain_rptr got %0d want %0d", rptr, (i + 1) % 6);
      end
    end
    n_cmp++; if (empty !== 1'b1 || free_slots !== 6) begin
      n_fail++; $display("FAIL drain_empty got empty=%b free=%0d want 1 6", empty, free_slots);
    end
  endtask

  task automatic test_errors();
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    n_cmp++; if (obs_of !== 1'b1 || used_slots !== 6 || err_sticky !== 2'b10) begin
      n_fail++; $display("FAIL ovf got of=%b used=%0d err=%b want 1 6 10", obs_of, used_slots, err_sticky);
    end
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    n_cmp++; if (obs_uf !== 1'b1 || err_sticky !== 2'b11) begin
      n_fail++; $display("FAIL udf got uf=%b err=%b want 1 11", obs_uf, err_sticky);
    end
    step(0, 0, 0, 1, 1);
    n_cmp++; if (err_sticky !== 2'b00) begin n_fail++; $display("FAIL errclr got %b want 00", err_sticky); end
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 1);
    step(1, 0, 0, 1, 1);
    n_cmp++; if (err_sticky !== 2'b10) begin n_fail++; $display("FAIL set_wins got %b want 10", err_sticky); end
  endtask

  task automatic test_simul();
    step(1, 1, 0, 0, 1);
    n_cmp++; if (obs_of !== 1'b1 || used_slots !== 5 || full !== 1'b0) begin
      n_fail++; $display("FAIL rw_full got of=%b used=%0d full=%b want 1 5 0", obs_of, used_slots, full);
    end
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 0, 1);
      n_cmp++; if (used_slots !== 3) begin n_fail++; $display("FAIL rw_used got %0d want 3", used_slots); end
      n_cmp++; if (rptr !== PW'(m_rc % D) || wptr !== PW'(m_wc % D)) begin
        n_fail++; $display("FAIL rw_ptr got %0d/%0d want %0d/%0d", rptr, wptr, m_rc % D, m_wc % D);
      end
    end
  endtask

  task automatic test_thresh();
    afth = 4; aeth = 1;
    step(0, 0, 1, 0, 1);
    for (int i = 1; i <= 4; i++) begin
      step(1, 0, 0, 0, 1);
      n_cmp++; if (almost_empty !== (i <= 1) || almost_full !== (i >= 4)) begin
        n_fail++; $display("FAIL thresh_w%0d got ae=%b af=%b want %b %b", i, almost_empty, almost_full,
                           i <= 1, i >= 4);
      end
    end
    afth = 6;
    step(0, 0, 0, 0, 1);
    n_cmp++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL thresh_chg got %b want 0", almost_full); end
  endtask

  task automatic test_clear();
    step(1, 0, 1, 0, 1);
    n_cmp++; if (used_slots !== 0 || rptr !== 0 || wptr !== 0 || empty !== 1'b1) begin
      n_fail++; $display("FAIL clear got used=%0d r=%0d w=%0d e=%b want 0 0 0 1", used_slots, rptr, wptr, empty);
    end
    n_cmp++; if (err_sticky !== 2'b10) begin n_fail++; $display("FAIL clear_err got %b want 10", err_sticky); end
    n_cmp++; if (watermark !== 0) begin n_fail++; $display("FAIL clear_wm got %0d want 0", watermark); end
  endtask

  task automatic test_reset_mid();
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0);
    n_cmp++; if (used_slots !== 0 || free_slots !== 6 || empty !== 1'b1 || full !== 1'b0) begin
      n_fail++; $display("FAIL rstmid got used=%0d free=%0d e=%b f=%b", used_slots, free_slots, empty, full);
    end
    n_cmp++; if (rptr !== 0 || wptr !== 0 || err_sticky !== 2'b00) begin
      n_fail++; $display("FAIL rstmid_ptr got r=%0d w=%0d err=%b want 0 0 00", rptr, wptr, err_sticky);
    end
  endtask

  task automatic test_random();
    int bias;
    bias = 50;
    for (int n = 0; n < 600; n++) begin
      if (n % 60 == 0) bias = (n / 60) % 3 == 0 ? 85 : ((n / 60) % 3 == 1 ? 15 : 50);
      if ($urandom_range(0, 15) == 0) afth = CW'($urandom_range(0, D));
      if ($urandom_range(0, 15) == 0) aeth = CW'($urandom_range(0, D));
      step($urandom_range(0, 99) < bias, $urandom_range(0, 99) >= bias,
           $urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0, $urandom_range(0, 255) != 0);
      n_cmp++; if (used_slots !== CW'(m_used)) begin
        n_fail++; $display("FAIL rnd_used got %0d want %0d", used_slots, m_used);
      end
      n_cmp++; if (free_slots !== CW'(D - m_used)) begin
        n_fail++; $display("FAIL rnd_free got %0d want %0d", free_slots, D - m_used);
      end
      n_cmp++; if (empty !== (m_used == 0) || full !== (m_used == D)) begin
        n_fail++; $display("FAIL rnd_ef got e=%b f=%b used=%0d", empty, full, m_used);
      end
      n_cmp++; if (almost_full !== (m_used >= afth) || almost_empty !== (m_used <= aeth)) begin
        n_fail++; $display("FAIL rnd_aflags got af=%b ae=%b used=%0d th=%0d/%0d", almost_full, almost_empty,
                           m_used, afth, aeth);
      end
      n_cmp++; if (rptr !== PW'(m_rc % D) || wptr !== PW'(m_wc % D)) begin
        n_fail++; $display("FAIL rnd_ptr got %0d/%0d want %0d/%0d", rptr, wptr, m_rc % D, m_wc % D);
      end
      n_cmp++; if (obs_of !== exp_of || obs_uf !== exp_uf) begin
        n_fail++; $display("FAIL rnd_ofuf got %b%b want %b%b", obs_of, obs_uf, exp_of, exp_uf);
      end
      n_cmp++; if (err_sticky !== m_err) begin
        n_fail++; $display("FAIL rnd_err got %b want %b", err_sticky, m_err);
      end
      n_cmp++; if (watermark !== CW'(m_wm)) begin
        n_fail++; $display("FAIL rnd_wm got %0d want %0d", watermark, m_wm);
      end
      n_cmp++; if (int'(used_slots) + int'(free_slots) != D || (empty && full)) begin
        n_fail++; $display("FAIL rnd_inv got used=%0d free=%0d e=%b f=%b", used_slots, free_slots, empty, full);
      end
    end
  endtask

  task automatic test_depth5();
    rst5_n = 1'b1; wen5 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (wptr5 !== 3'((i + 1) % 5)) begin
        n_fail++; $display("FAIL d5_wptr got %0d want %0d", wptr5, (i + 1) % 5);
      end
    end
    n_cmp++; if (full5 !== 1'b1 || used5 !== 5) begin
      n_fail++; $display("FAIL d5_full got f=%b used=%0d want 1 5", full5, used5);
    end
    wen5 = 1'b0; ren5 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (rptr5 !== 3'((i + 1) % 5)) begin
        n_fail++; $display("FAIL d5_rptr got %0d want %0d", rptr5, (i + 1) % 5);
      end
    end
    n_cmp++; if (empty5 !== 1'b1) begin n_fail++; $display("FAIL d5_empty got %b want 1", empty5); end
    ren5 = 1'b0;
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; wen = 1'b0; ren = 1'b0; clear = 1'b0; err_clr = 1'b0;
    afth = 4; aeth = 1;
    rst5_n = 1'b0; wen5 = 1'b0; ren5 = 1'b0; clr5 = 1'b0; eclr5 = 1'b0; afth5 = 3; aeth5 = 1;
    n_cmp = 0; n_fail = 0;
    m_used = 0; m_wc = 0; m_rc = 0; m_wm = 0; m_err = 2'b00;
    test_reset();
    test_fill_wrap();
    test_errors();
    test_simul();
    test_thresh();
    test_clear();
    test_reset_mid();
    test_random();
    test_depth5();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
